// File: rtl/uart_fifo_if.sv
// CSR bus between the system interconnect and one uart_fifo instance.
interface uart_fifo_if;
   logic [13:0] csr_a;
   logic        csr_we;
   logic [31:0] csr_di;
   logic [31:0] csr_do;

   modport master (output csr_a, output csr_we, output csr_di, input csr_do);
   modport slave  (input csr_a, input csr_we, input csr_di, output csr_do);
endinterface

// File: rtl/uart_fifo.sv
// CSR-mapped UART with TX/RX FIFOs, optional parity, 1/2 stop bits and level interrupts.
// Bit timing is 16 * divisor sys_clk cycles per bit in both directions.
module uart_fifo #(
   parameter logic [3:0]  csr_addr  = 4'h0,
   parameter int unsigned clk_freq  = 100000000,
   parameter int unsigned baud      = 115200,
   parameter int unsigned fifo_log2 = 4
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   uart_fifo_if.slave csr,
   output logic       rx_irq,
   output logic       tx_irq,
   input  logic       uart_rx,
   output logic       uart_tx
);
   localparam int unsigned Depth  = 2 ** fifo_log2;
   localparam logic [15:0] DefDiv = 16'(clk_freq / baud / 16);

   typedef logic [fifo_log2-1:0] ptr_t;
   typedef logic [fifo_log2:0]   cnt_t;
   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

   localparam ptr_t PtrOne = ptr_t'(1);
   localparam cnt_t CntOne = cnt_t'(1);

   logic        sel, wr, rd, st_wr;
   logic [2:0]  reg_sel;
   logic [15:0] div_q, div_eff;
   logic [5:0]  ctrl_q;
   logic        rx_ovr_q, frame_err_q, par_err_q, tx_ovf_q;
   logic [31:0] csr_do_q, rd_val, status;
   logic        rx_irq_q, tx_irq_q, unused_bits;

   logic [7:0]  tx_mem [Depth];
   logic [7:0]  rx_mem [Depth];
   ptr_t        tx_wp_q, tx_rp_q, rx_wp_q, rx_rp_q;
   cnt_t        tx_cnt_q, rx_cnt_q;
   logic        tx_full, tx_empty, rx_full, rx_empty;
   logic        tx_push_req, tx_push, tx_pop, rx_push_req, rx_push, rx_pop;

   logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

   state_e      tx_state_q, tx_state_d;
   logic [20:0] tx_tick_q, tx_last;
   logic [2:0]  tx_idx_q;
   logic [7:0]  tx_sh_q;
   logic [15:0] tx_div_q;
   logic        tx_par_q, tx_par_en_q, tx_two_stop_q, tx_done, tx_line;

   state_e      rx_state_q, rx_state_d;
   logic [20:0] rx_tick_q, rx_last;
   logic [2:0]  rx_idx_q;
   logic [7:0]  rx_sh_q;
   logic [15:0] rx_div_q;
   logic        rx_par_q, rx_done, rx_stop_smp, rx_par_bad, rx_fe_set, rx_pe_set;

   assign sel         = csr.csr_a[13:10] == csr_addr;
   assign wr          = sel & csr.csr_we;
   assign rd          = sel & ~csr.csr_we;
   assign reg_sel     = csr.csr_a[2:0];
   assign st_wr       = wr & (reg_sel == 3'd2);
   assign div_eff     = (div_q == '0) ? 16'd1 : div_q;
   assign unused_bits = ^{csr.csr_a[9:3], csr.csr_di[31:16]};

   assign tx_full     = tx_cnt_q == cnt_t'(Depth);
   assign tx_empty    = tx_cnt_q == '0;
   assign rx_full     = rx_cnt_q == cnt_t'(Depth);
   assign rx_empty    = rx_cnt_q == '0;
   // A pop in the same cycle frees the slot, so a push on full-with-pop is kept.
   assign tx_push_req = wr & (reg_sel == 3'd0);
   assign tx_push     = tx_push_req & (~tx_full | tx_pop);
   assign rx_pop      = rd & (reg_sel == 3'd0) & ~rx_empty;
   assign rx_push     = rx_push_req & (~rx_full | rx_pop);

   always_ff @(posedge sys_clk) begin
      if (tx_push) tx_mem[tx_wp_q] <= csr.csr_di[7:0];
      if (rx_push) rx_mem[rx_wp_q] <= rx_sh_q;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tx_wp_q  <= '0;
         tx_rp_q  <= '0;
         tx_cnt_q <= '0;
         rx_wp_q  <= '0;
         rx_rp_q  <= '0;
         rx_cnt_q <= '0;
      end else begin
         if (tx_push) tx_wp_q <= tx_wp_q + PtrOne;
         if (tx_pop)  tx_rp_q <= tx_rp_q + PtrOne;
         if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + CntOne;
         else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - CntOne;
         if (rx_push) rx_wp_q <= rx_wp_q + PtrOne;
         if (rx_pop)  rx_rp_q <= rx_rp_q + PtrOne;
         if (rx_push && !rx_pop)      rx_cnt_q <= rx_cnt_q + CntOne;
         else if (!rx_push && rx_pop) rx_cnt_q <= rx_cnt_q - CntOne;
      end
   end

   // ---------------- transmitter ----------------
   always_comb begin
      tx_last = {1'b0, tx_div_q, 4'b0} - 21'd1;
      if (tx_state_q == StStop && tx_two_stop_q) tx_last = {tx_div_q, 5'b0} - 21'd1;
   end
   assign tx_done = (tx_state_q != StIdle) && (tx_tick_q == tx_last);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         tx_state_q    <= StIdle;
         tx_tick_q     <= '0;
         tx_idx_q      <= '0;
         tx_sh_q       <= '0;
         tx_div_q      <= 16'd1;
         tx_par_q      <= 1'b0;
         tx_par_en_q   <= 1'b0;
         tx_two_stop_q <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_tick_q  <= (tx_state_q == StIdle || tx_done) ? '0 : tx_tick_q + 21'd1;
         // Frame format and divisor are frozen when the byte leaves the FIFO.
         if (tx_pop) begin
            tx_sh_q       <= tx_mem[tx_rp_q];
            tx_par_q      <= ^tx_mem[tx_rp_q] ^ ctrl_q[2];
            tx_par_en_q   <= ctrl_q[1];
            tx_two_stop_q <= ctrl_q[3];
            tx_div_q      <= div_eff;
            tx_idx_q      <= '0;
         end else if (tx_state_q == StData && tx_done) begin
            tx_sh_q  <= tx_sh_q >> 1;
            tx_idx_q <= tx_idx_q + 3'd1;
         end
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      unique case (tx_state_q)
         StIdle:   if (!tx_empty) tx_state_d = StStart;
         StStart:  if (tx_done) tx_state_d = StData;
         StData:   if (tx_done && tx_idx_q == 3'd7) tx_state_d = tx_par_en_q ? StParity : StStop;
         StParity: if (tx_done) tx_state_d = StStop;
         StStop:   if (tx_done) tx_state_d = tx_empty ? StIdle : StStart;
         default:  tx_state_d = StIdle;
      endcase
   end

   always_comb begin
      tx_line = 1'b1;
      tx_pop  = 1'b0;
      unique case (tx_state_q)
         StIdle:   tx_pop = ~tx_empty;
         StStart:  tx_line = 1'b0;
         StData:   tx_line = tx_sh_q[0];
         StParity: tx_line = tx_par_q;
         StStop:   tx_pop = tx_done & ~tx_empty;
         default:  tx_line = 1'b1;
      endcase
   end

   // ---------------- receiver ----------------
   assign rx_fall = rx_prev_q & ~rx_s2_q;
   always_comb begin
      rx_last = {1'b0, rx_div_q, 4'b0} - 21'd1;
      if (rx_state_q == StStart) rx_last = {2'b0, rx_div_q, 3'b0} - 21'd1;
   end
   assign rx_done = (rx_state_q != StIdle) && (rx_tick_q == rx_last);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         rx_state_q <= StIdle;
         rx_tick_q  <= '0;
         rx_idx_q   <= '0;
         rx_sh_q    <= '0;
         rx_div_q   <= 16'd1;
         rx_par_q   <= 1'b0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_tick_q  <= (rx_state_q == StIdle || rx_done) ? '0 : rx_tick_q + 21'd1;
         if (rx_state_q == StIdle && rx_fall) begin
            rx_div_q <= div_eff;
            rx_idx_q <= '0;
         end else if (rx_state_q == StData && rx_done) begin
            rx_sh_q  <= {rx_s2_q, rx_sh_q[7:1]};
            rx_idx_q <= rx_idx_q + 3'd1;
         end else if (rx_state_q == StParity && rx_done) begin
            rx_par_q <= rx_s2_q;
         end
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      unique case (rx_state_q)
         StIdle:   if (rx_fall) rx_state_d = StStart;
         StStart:  if (rx_done) rx_state_d = rx_s2_q ? StIdle : StData;
         StData:   if (rx_done && rx_idx_q == 3'd7) rx_state_d = ctrl_q[1] ? StParity : StStop;
         StParity: if (rx_done) rx_state_d = StStop;
         StStop:   if (rx_done) rx_state_d = StIdle;
         default:  rx_state_d = StIdle;
      endcase
   end

   always_comb begin
      rx_stop_smp = (rx_state_q == StStop) & rx_done;
      rx_par_bad  = ctrl_q[1] & (rx_par_q != (^rx_sh_q ^ ctrl_q[2]));
      rx_fe_set   = rx_stop_smp & ~rx_s2_q;
      rx_pe_set   = rx_stop_smp & rx_s2_q & rx_par_bad;
      rx_push_req = rx_stop_smp & rx_s2_q & ~rx_par_bad;
   end

   // ---------------- CSR and status ----------------
   always_comb begin
      status = '0;
      status[fifo_log2:0]       = tx_cnt_q;
      status[fifo_log2+16:16]   = rx_cnt_q;
      status[8]  = tx_state_q != StIdle;
      status[9]  = rx_ovr_q;
      status[10] = frame_err_q;
      status[11] = par_err_q;
      status[12] = tx_ovf_q;
      case (reg_sel)
         3'd0:    rd_val = {23'b0, ~rx_empty, rx_empty ? 8'h00 : rx_mem[rx_rp_q]};
         3'd1:    rd_val = {16'b0, div_q};
         3'd2:    rd_val = status;
         3'd3:    rd_val = {26'b0, ctrl_q};
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         div_q       <= DefDiv;
         ctrl_q      <= '0;
         rx_ovr_q    <= 1'b0;
         frame_err_q <= 1'b0;
         par_err_q   <= 1'b0;
         tx_ovf_q    <= 1'b0;
         csr_do_q    <= '0;
         rx_irq_q    <= 1'b0;
         tx_irq_q    <= 1'b0;
         rx_s1_q     <= 1'b1;
         rx_s2_q     <= 1'b1;
         rx_prev_q   <= 1'b1;
      end else begin
         if (wr && reg_sel == 3'd1) div_q <= csr.csr_di[15:0];
         if (wr && reg_sel == 3'd3) ctrl_q <= csr.csr_di[5:0];
         // Set wins over a simultaneous clear so no event is lost.
         rx_ovr_q    <= (rx_push_req & rx_full & ~rx_pop) | (rx_ovr_q & ~(st_wr & csr.csr_di[9]));
         frame_err_q <= rx_fe_set | (frame_err_q & ~(st_wr & csr.csr_di[10]));
         par_err_q   <= rx_pe_set | (par_err_q & ~(st_wr & csr.csr_di[11]));
         tx_ovf_q    <= (tx_push_req & tx_full & ~tx_pop) | (tx_ovf_q & ~(st_wr & csr.csr_di[12]));
         csr_do_q    <= rd ? rd_val : '0;
         rx_irq_q    <= ctrl_q[4] & ~rx_empty;
         tx_irq_q    <= ctrl_q[5] & tx_empty & (tx_state_q == StIdle);
         rx_s1_q     <= uart_rx;
         rx_s2_q     <= rx_s1_q;
         rx_prev_q   <= rx_s2_q;
      end
   end

   assign csr.csr_do = csr_do_q;
   assign rx_irq     = rx_irq_q;
   assign tx_irq     = tx_irq_q;
   assign uart_tx    = ctrl_q[0] ? rx_s2_q : tx_line;
endmodule
